microwave_timer_ctrl: RTL

- Cook-time controller sequencing the keypad encoder output into a 4-digit BCD MM:SS time register, then counting it down while the magnetron is enabled.
- Sits between the keypad encoder (digit + valid strobe) and the display/magnetron drivers.
- Owns the cook state machine (IDLE, COOK, PAUSE, DONE) and the seconds prescaler.

---
 rtl/microwave_timer_ctrl.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/microwave_timer_ctrl.sv
// Microwave cook-time controller: keypad digit entry into an MM:SS BCD register,
// then a prescaled countdown with an IDLE/COOK/PAUSE/DONE state machine.
module microwave_timer_ctrl #(
  parameter int CLK_PER_SEC = 10,
  parameter int PRESCALE_W  = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [3:0] digit,
  input  logic       start,
  input  logic       stop_clear,
  input  logic       door_closed,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       mag_on,
  output logic       done,
  output logic [1:0] state
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_COOK  = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [PRESCALE_W-1:0] PRE_MAX = PRESCALE_W'(CLK_PER_SEC - 1);

  logic [1:0]            state_q, state_d;
  logic [3:0]            mt_q, mt_d, mo_q, mo_d, st_q, st_d, so_q, so_d;
  logic [PRESCALE_W-1:0] pre_q, pre_d;
  logic                  mag_on_q, done_q;

  logic [3:0] dec_mt, dec_mo, dec_st, dec_so;
  logic       time_zero, dec_zero;

  assign time_zero = (mt_q == 4'd0) && (mo_q == 4'd0) && (st_q == 4'd0) && (so_q == 4'd0);

  // One-second BCD decrement; seconds tens may exceed 5 when typed in (e.g. 75).
  always_comb begin
    dec_mt = mt_q;
    dec_mo = mo_q;
    dec_st = st_q;
    dec_so = so_q;
    if (st_q != 4'd0 || so_q != 4'd0) begin
      if (so_q == 4'd0) begin
        dec_so = 4'd9;
        dec_st = st_q - 4'd1;
      end else begin
        dec_so = so_q - 4'd1;
      end
    end else begin
      dec_st = 4'd5;
      dec_so = 4'd9;
      if (mo_q == 4'd0) begin
        dec_mo = 4'd9;
        dec_mt = mt_q - 4'd1;
      end else begin
        dec_mo = mo_q - 4'd1;
      end
    end
    dec_zero = (dec_mt == 4'd0) && (dec_mo == 4'd0) && (dec_st == 4'd0) && (dec_so == 4'd0);
  end

  always_comb begin
    state_d = state_q;
    mt_d    = mt_q;
    mo_d    = mo_q;
    st_d    = st_q;
    so_d    = so_q;
    pre_d   = pre_q;
    case (state_q)
      S_IDLE: begin
        if (stop_clear) begin
          {mt_d, mo_d, st_d, so_d} = 16'h0000;
        end else if (!door_closed) begin
          // Door open: start is refused; digit entry is still allowed.
          if (!start && key_valid && digit <= 4'd9) begin
            {mt_d, mo_d, st_d, so_d} = {mo_q, st_q, so_q, digit};
          end
        end else if (start) begin
          if (!time_zero) begin
            state_d = S_COOK;
            pre_d   = '0;
          end
        end else if (key_valid && digit <= 4'd9) begin
          {mt_d, mo_d, st_d, so_d} = {mo_q, st_q, so_q, digit};
        end
      end
      S_COOK: begin
        if (stop_clear || !door_closed) begin
          state_d = S_PAUSE;
        end else if (pre_q == PRE_MAX) begin
          pre_d = '0;
          {mt_d, mo_d, st_d, so_d} = {dec_mt, dec_mo, dec_st, dec_so};
          if (dec_zero) state_d = S_DONE;
        end else begin
          pre_d = pre_q + PRESCALE_W'(1);
        end
      end
      S_PAUSE: begin
        if (stop_clear) begin
          state_d = S_IDLE;
          {mt_d, mo_d, st_d, so_d} = 16'h0000;
        end else if (door_closed && start) begin
          state_d = S_COOK;
        end
      end
      default: begin
        if (key_valid || stop_clear || start || !door_closed) state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      mt_q     <= 4'd0;
      mo_q     <= 4'd0;
      st_q     <= 4'd0;
      so_q     <= 4'd0;
      pre_q    <= '0;
      mag_on_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mt_q     <= mt_d;
      mo_q     <= mo_d;
      st_q     <= st_d;
      so_q     <= so_d;
      pre_q    <= pre_d;
      mag_on_q <= (state_d == S_COOK);
      done_q   <= (state_d == S_DONE);
    end
  end

  assign min_tens = mt_q;
  assign min_ones = mo_q;
  assign sec_tens = st_q;
  assign sec_ones = so_q;
  assign mag_on   = mag_on_q;
  assign done     = done_q;
  assign state    = state_q;

endmodule
